// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Brief    : Operand/result handshake bundle for serial_adder. The out_ovf
//            signal exists only when SERIAL_ADD_OVF_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             out_ovf;
`endif

  modport master (
`ifdef SERIAL_ADD_OVF_EN
    input  out_ovf,
`endif
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
`ifdef SERIAL_ADD_OVF_EN
    output out_ovf,
`endif
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : WIDTH-bit adder built from one bit-serial full-add cell, LSB
//            first, with valid/ready on both sides. Define SERIAL_ADD_OVF_EN
//            to add the registered signed-overflow output.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst,
  serial_adder_if.slave bus
);
  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_carry;
  logic             r_cout;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             w_accept;
  logic             w_last;

  // Full add as two half-add cells; the carry is held in r_carry between bits.
  logic w_h1_s, w_h1_c, w_h2_c, w_sum_bit, w_carry_next;
  assign w_h1_s       = r_a[0] ^ r_b[0];
  assign w_h1_c       = r_a[0] & r_b[0];
  assign w_sum_bit    = w_h1_s ^ r_carry;
  assign w_h2_c       = w_h1_s & r_carry;
  assign w_carry_next = w_h1_c | w_h2_c;

  // Sum bits enter the vacated MSB of the A shifter, so after WIDTH shifts
  // it holds the full sum and no separate accumulator is needed.
  logic [WIDTH-1:0] w_a_next;
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_a_next = w_sum_bit;
    end else begin : g_wn
      assign w_a_next = {w_sum_bit, r_a[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == C_LAST) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      // Status flags follow the next state, so in_ready first rises one edge after reset.
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == DONE);
      r_busy      <= (w_state_next != IDLE);
      if (w_accept) begin
        r_a     <= bus.in_a;
        r_b     <= bus.in_b;
        r_carry <= bus.in_cin;
        r_count <= '0;
      end else if (r_state == SHIFT) begin
        r_a     <= w_a_next;
        r_b     <= r_b >> 1;
        r_carry <= w_carry_next;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_sum  <= w_a_next;
          r_cout <= w_carry_next;
        end
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
  // On the last shift edge r_carry is the carry into the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_carry_next;
    end
  end
  assign bus.out_ovf = r_ovf;
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cout  = r_cout;
  assign bus.busy      = r_busy;
endmodule
`default_nettype wire
